// File: rtl/intpol2_pkg.sv
// Shared definitions for the 2x interpolator output path.
package intpol2_pkg;

    localparam int unsigned DATAPATH_WIDTH  = 12;
    localparam int unsigned AF_DIFF_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } pacer_state_t;

endpackage

// File: rtl/intpol2_sync_fifo.sv
// Single-clock I/Q pair FIFO with level tracking and registered read data.
module intpol2_sync_fifo #(
    parameter int unsigned DW      = intpol2_pkg::DATAPATH_WIDTH,
    parameter int unsigned AW      = 3,
    parameter int unsigned AF_DIFF = intpol2_pkg::AF_DIFF_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_i,
    input  logic [DW-1:0] wr_q,
    output logic [DW-1:0] rd_i,
    output logic [DW-1:0] rd_q,
    output logic [AW:0]   level,
    output logic          full_c,
    output logic          afull_c,
    output logic          empty_c
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [DW-1:0] mem_i [DEPTH];
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full_c  = (level == LW'(DEPTH));
    assign afull_c = (level >= LW'(DEPTH - AF_DIFF));
    assign empty_c = (level == '0);

    // A full FIFO still takes a push when a pop frees the slot in the same cycle.
    assign push_ok = push && (!full_c || pop) && !flush;
    assign pop_ok  = pop && !empty_c && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_i[wptr] <= wr_i;
            mem_q[wptr] <= wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            rd_i  <= '0;
            rd_q  <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
                rd_i <= mem_i[rptr];
                rd_q <= mem_q[rptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/intpol2_iq_out_pacer.sv
// Paces interpolator I/Q pairs out of a FIFO at a programmable strobe rate.
module intpol2_iq_out_pacer #(
    parameter int unsigned DATAPATH_WIDTH = intpol2_pkg::DATAPATH_WIDTH,
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned AF_DIFF        = intpol2_pkg::AF_DIFF_DEFAULT,
    parameter int unsigned DIV_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [DIV_WIDTH-1:0]      rate_div_i,
    input  logic [ADDR_WIDTH:0]       prime_lvl_i,
    input  logic                      wr_en_i,
    input  logic [DATAPATH_WIDTH-1:0] I_in,
    input  logic [DATAPATH_WIDTH-1:0] Q_in,
    output logic                      afull_o,
    output logic                      full_o,
    output logic [ADDR_WIDTH:0]       level_o,
    output logic [DATAPATH_WIDTH-1:0] dac_I_o,
    output logic [DATAPATH_WIDTH-1:0] dac_Q_o,
    output logic                      dac_valid_o,
    output logic [1:0]                state_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);

    import intpol2_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;

    pacer_state_t         state_q;
    pacer_state_t         state_nxt;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [LW-1:0]        prime_eff;
    logic                 empty_c;
    logic                 tick_c;
    logic                 pop_c;
    logic                 underflow_set_c;
    logic                 load_div_c;

    intpol2_sync_fifo #(
        .DW      (DATAPATH_WIDTH),
        .AW      (ADDR_WIDTH),
        .AF_DIFF (AF_DIFF)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (clear_i),
        .push    (wr_en_i),
        .pop     (pop_c),
        .wr_i    (I_in),
        .wr_q    (Q_in),
        .rd_i    (dac_I_o),
        .rd_q    (dac_Q_o),
        .level   (level_o),
        .full_c  (full_o),
        .afull_c (afull_o),
        .empty_c (empty_c)
    );

    assign state_o = state_q;

    // Prime threshold clamped to 1..DEPTH.
    always_comb begin
        prime_eff = prime_lvl_i;
        if (prime_lvl_i == '0) begin
            prime_eff = LW'(1);
        end else if (prime_lvl_i > LW'(DEPTH)) begin
            prime_eff = LW'(DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (clear_i || !enable_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_nxt = ST_PRIME;
                ST_PRIME: if (level_o >= prime_eff) state_nxt = ST_RUN;
                ST_RUN:   if (tick_c && empty_c) state_nxt = ST_PRIME;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // A tick scheduled in the cycle enable drops still pops; clear cancels it.
    always_comb begin
        tick_c          = (state_q == ST_RUN) && (cnt_q == div_q);
        pop_c           = tick_c && !empty_c && !clear_i;
        underflow_set_c = tick_c && empty_c && !clear_i;
        load_div_c      = (state_q == ST_IDLE) && enable_i && !clear_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            cnt_q       <= '0;
            dac_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clear_i) begin
            cnt_q       <= '0;
            dac_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (load_div_c) div_q <= rate_div_i;
            if (state_q == ST_RUN) cnt_q <= tick_c ? '0 : cnt_q + DIV_WIDTH'(1);
            else                   cnt_q <= '0;
            dac_valid_o <= pop_c;
            if (wr_en_i && full_o && !pop_c) overflow_o <= 1'b1;
            if (underflow_set_c) underflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_intpol2_iq_out_pacer.sv
// Directed bench for the I/Q output pacer.
module tb_intpol2_iq_out_pacer;

    logic        clk;
    logic        rst;
    logic        enable_i;
    logic        clear_i;
    logic [7:0]  rate_div_i;
    logic [3:0]  prime_lvl_i;
    logic        wr_en_i;
    logic [11:0] I_in;
    logic [11:0] Q_in;
    logic        afull_o;
    logic        full_o;
    logic [3:0]  level_o;
    logic [11:0] dac_I_o;
    logic [11:0] dac_Q_o;
    logic        dac_valid_o;
    logic [1:0]  state_o;
    logic        overflow_o;
    logic        underflow_o;

    int checks;
    int failures;

    typedef struct {
        logic        wr;
        logic [11:0] i;
        logic [3:0]  lvl;
        logic        af;
        logic        fl;
        logic        ovf;
    } ovf_vec_t;

    ovf_vec_t tbl [10];

    intpol2_iq_out_pacer dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .rate_div_i  (rate_div_i),
        .prime_lvl_i (prime_lvl_i),
        .wr_en_i     (wr_en_i),
        .I_in        (I_in),
        .Q_in        (Q_in),
        .afull_o     (afull_o),
        .full_o      (full_o),
        .level_o     (level_o),
        .dac_I_o     (dac_I_o),
        .dac_Q_o     (dac_Q_o),
        .dac_valid_o (dac_valid_o),
        .state_o     (state_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        clear_i  = 1'b1;
        enable_i = 1'b0;
        wr_en_i  = 1'b0;
        step();
        clear_i  = 1'b0;
    endtask

    initial begin
        logic [11:0] qe;
        int          idx;
        logic        ev;

        checks = 0;
        failures = 0;
        rst = 1'b1; enable_i = 1'b0; clear_i = 1'b0; rate_div_i = '0;
        prime_lvl_i = '0; wr_en_i = 1'b0; I_in = '0; Q_in = '0;

        tbl[0] = '{1'b1, 12'd17, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 12'd18, 4'd2, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 12'd19, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 12'd20, 4'd4, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 12'd21, 4'd5, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 12'd22, 4'd6, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 12'd23, 4'd7, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 12'd24, 4'd8, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 12'd25, 4'd8, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 12'd0,  4'd8, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (2) step();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_outs", {afull_o, full_o, dac_valid_o, overflow_o, underflow_o, dac_I_o, dac_Q_o}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_state", 32'(state_o), 32'd0);

        // Prime and pace: prime 4, div 3, six pairs I=k, Q=-k
        enable_i = 1'b1; rate_div_i = 8'd3; prime_lvl_i = 4'd4;
        for (int k = 1; k <= 6; k++) begin
            wr_en_i = 1'b1; I_in = 12'(k); Q_in = 12'(0 - k);
            step();
            if (k == 1) chk("pace_prime_entry", 32'(state_o), 32'd1);
            if (k == 4) chk("pace_still_prime", 32'(state_o), 32'd1);
            if (k == 5) chk("pace_run_entry", 32'(state_o), 32'd2);
        end
        wr_en_i = 1'b0;
        for (int c = 7; c <= 31; c++) begin
            step();
            ev = (c >= 9) && (c <= 29) && (((c - 9) % 4) == 0);
            chk("pace_valid", 32'(dac_valid_o), 32'(ev));
            if (ev) begin
                idx = (c - 9) / 4 + 1;
                qe = 12'(0 - idx);
                chk("pace_I", 32'(dac_I_o), 32'(idx));
                chk("pace_Q", 32'(dac_Q_o), 32'(qe));
            end
        end
        chk("pace_drained", 32'(level_o), 32'd0);
        chk("pace_no_unf", 32'(underflow_o), 32'd0);
        clear_pulse();
        chk("clr1_state", 32'(state_o), 32'd0);

        // Almost-full / overflow table, pacer disabled
        for (int n = 0; n < 10; n++) begin
            wr_en_i = tbl[n].wr; I_in = tbl[n].i; Q_in = 12'd0;
            step();
            chk("tbl_level", 32'(level_o), 32'(tbl[n].lvl));
            chk("tbl_afull", 32'(afull_o), 32'(tbl[n].af));
            chk("tbl_full", 32'(full_o), 32'(tbl[n].fl));
            chk("tbl_ovf", 32'(overflow_o), 32'(tbl[n].ovf));
            chk("tbl_state", 32'(state_o), 32'd0);
        end
        clear_pulse();
        chk("clr2_level", 32'(level_o), 32'd0);
        chk("clr2_ovf", 32'(overflow_o), 32'd0);

        // Full FIFO in RUN with push on the tick cycle
        for (int k = 1; k <= 8; k++) begin
            wr_en_i = 1'b1; I_in = 12'(k); Q_in = 12'(k + 50);
            step();
        end
        wr_en_i = 1'b0;
        chk("fill_full", 32'(full_o), 32'd1);
        enable_i = 1'b1; rate_div_i = 8'd3; prime_lvl_i = 4'd4;
        step();
        chk("full_prime", 32'(state_o), 32'd1);
        step();
        chk("full_run", 32'(state_o), 32'd2);
        repeat (3) step();
        chk("full_pre_tick_valid", 32'(dac_valid_o), 32'd0);
        wr_en_i = 1'b1; I_in = 12'd100; Q_in = 12'd200;
        step();
        wr_en_i = 1'b0;
        chk("pp_level", 32'(level_o), 32'd8);
        chk("pp_ovf", 32'(overflow_o), 32'd0);
        chk("pp_valid", 32'(dac_valid_o), 32'd1);
        chk("pp_I", 32'(dac_I_o), 32'd1);
        chk("pp_Q", 32'(dac_Q_o), 32'd51);

        // Clear mid-RUN with a concurrent push
        clear_i = 1'b1; enable_i = 1'b0; wr_en_i = 1'b1; I_in = 12'd300;
        step();
        clear_i = 1'b0; wr_en_i = 1'b0;
        chk("clr_level", 32'(level_o), 32'd0);
        chk("clr_state", 32'(state_o), 32'd0);
        chk("clr_flags", {overflow_o, underflow_o, dac_valid_o}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("clr_quiet", {dac_valid_o, level_o}, 32'd0);
        end

        // Underflow with div 0 and two pairs
        wr_en_i = 1'b1; I_in = 12'h7FF; Q_in = 12'h800;
        step();
        I_in = 12'h123; Q_in = 12'hEDD;
        step();
        wr_en_i = 1'b0;
        enable_i = 1'b1; rate_div_i = 8'd0; prime_lvl_i = 4'd2;
        step();
        chk("uf_prime", 32'(state_o), 32'd1);
        step();
        chk("uf_run", 32'(state_o), 32'd2);
        step();
        chk("uf_v1", {dac_valid_o, dac_I_o, dac_Q_o}, {1'b1, 12'h7FF, 12'h800});
        step();
        chk("uf_v2", {dac_valid_o, dac_I_o, dac_Q_o}, {1'b1, 12'h123, 12'hEDD});
        chk("uf_not_yet", 32'(underflow_o), 32'd0);
        step();
        chk("uf_flag", 32'(underflow_o), 32'd1);
        chk("uf_state", 32'(state_o), 32'd1);
        chk("uf_hold", {dac_valid_o, dac_I_o, dac_Q_o}, {1'b0, 12'h123, 12'hEDD});
        step();
        chk("uf_sticky", {underflow_o, state_o}, {1'b1, 2'd1});

        // Synchronous reset mid-operation
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_outs", {afull_o, full_o, dac_valid_o, overflow_o, underflow_o, state_o, level_o, dac_I_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
